// File: rtl/up_sample_sched_if.sv
// Control bundle between up_sample_sched and the stencil buffers and stream ports.
// The master side is the scheduler; the slave side is the surrounding pipeline.
interface up_sample_sched_if #(
  parameter int unsigned CTRL_W = 16
);
  logic                   flush;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   in_valid;
  logic                   in_ready;
  logic                   hw_input_write_wen;
  logic [2:0][CTRL_W-1:0] hw_input_write_ctrl_vars;
  logic [2:0][CTRL_W-1:0] hw_input_read_ctrl_vars;
  logic                   nn_read_ren;
  logic                   nn_write_wen;
  logic [2:0][CTRL_W-1:0] nn_ctrl_vars;
  logic                   out_valid;
  logic                   out_ready;
  logic                   hw_output_read_ren;
  logic [2:0][CTRL_W-1:0] hw_output_read_ctrl_vars;
  logic                   out_last;

  modport master (
    input  flush, start, in_valid, out_ready,
    output busy, done, in_ready, hw_input_write_wen, hw_input_write_ctrl_vars,
           hw_input_read_ctrl_vars, nn_read_ren, nn_write_wen, nn_ctrl_vars,
           out_valid, hw_output_read_ren, hw_output_read_ctrl_vars, out_last
  );

  modport slave (
    output flush, start, in_valid, out_ready,
    input  busy, done, in_ready, hw_input_write_wen, hw_input_write_ctrl_vars,
           hw_input_read_ctrl_vars, nn_read_ren, nn_write_wen, nn_ctrl_vars,
           out_valid, hw_output_read_ren, hw_output_read_ctrl_vars, out_last
  );
endinterface

// File: rtl/up_sample_sched.sv
// Frame scheduler for up_sample: LOAD input ub, COMPUTE nearest_neighbor sweep, DRAIN output.
// Define UP_SAMPLE_SCHED_PERF_EN to add the stall_cnt / frame_cnt performance outputs.
module up_sample_sched #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned IN_H   = 64,
  parameter int unsigned SCALE  = 2,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  up_sample_sched_if.master bus
`ifdef UP_SAMPLE_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       frame_cnt
`endif
);
  localparam int unsigned OUT_W = IN_W * SCALE;
  localparam int unsigned OUT_H = IN_H * SCALE;
  localparam int unsigned XW    = $clog2(OUT_W);
  localparam int unsigned YW    = $clog2(OUT_H);
  localparam int unsigned SH    = $clog2(SCALE);

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_lim;
  logic [YW-1:0] y_q, y_d, y_lim;
  logic          done_q, done_d;
  logic          step;
  logic          at_end;

  // One (x,y) counter pair is shared by all phases; only the wrap limits differ.
  always_comb begin
    x_lim  = (state_q == StLoad) ? XW'(IN_W - 1) : XW'(OUT_W - 1);
    y_lim  = (state_q == StLoad) ? YW'(IN_H - 1) : YW'(OUT_H - 1);
    at_end = (x_q == x_lim) && (y_q == y_lim);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        step = bus.hw_input_write_wen;
        if (step && at_end) state_d = StCompute;
      end
      StCompute: begin
        step = 1'b1;
        if (at_end) state_d = StDrain;
      end
      StDrain: begin
        step = bus.hw_output_read_ren;
        if (step && at_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (step) begin
      x_d = x_q + 1'b1;
      if (x_q == x_lim) begin
        x_d = '0;
        y_d = (y_q == y_lim) ? '0 : y_q + 1'b1;
      end
    end
    if (bus.flush) begin
      state_d = StIdle;
      x_d     = '0;
      y_d     = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  logic [2:0][CTRL_W-1:0] ctrl_cur, ctrl_src;

  always_comb begin
    ctrl_cur[0] = '0;
    ctrl_cur[1] = CTRL_W'(y_q);
    ctrl_cur[2] = CTRL_W'(x_q);
    // Nearest-neighbour source pixel in the input ub.
    ctrl_src[0] = '0;
    ctrl_src[1] = CTRL_W'(y_q >> SH);
    ctrl_src[2] = CTRL_W'(x_q >> SH);
  end

  assign bus.busy                     = (state_q != StIdle);
  assign bus.done                     = done_q;
  assign bus.in_ready                 = (state_q == StLoad);
  assign bus.hw_input_write_wen       = bus.in_valid & bus.in_ready;
  assign bus.hw_input_write_ctrl_vars = ctrl_cur;
  assign bus.hw_input_read_ctrl_vars  = ctrl_src;
  assign bus.nn_read_ren              = (state_q == StCompute);
  assign bus.nn_write_wen             = (state_q == StCompute);
  assign bus.nn_ctrl_vars             = ctrl_cur;
  assign bus.out_valid                = (state_q == StDrain);
  assign bus.hw_output_read_ren       = bus.out_valid & bus.out_ready;
  assign bus.hw_output_read_ctrl_vars = ctrl_cur;
  assign bus.out_last                 = bus.out_valid & at_end;

`ifdef UP_SAMPLE_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start;

  assign frame_start = (state_q == StIdle) && bus.start && !bus.flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      stall_cnt_d = '0;
    end else if (((state_q == StLoad) && !bus.in_valid) ||
                 ((state_q == StDrain) && !bus.out_ready)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign frame_cnt = frame_cnt_q;
`endif
endmodule
